// File: rtl/verif_init_seq.sv
// verif_init_seq: lock-step harness sequencer. On an accepted start it loads
// identical initial state into the reference model and the core (all
// architectural registers, then the first data-memory words), holds the core
// in reset for RESET_HOLD cycles, then streams RUN_CYCLES program words.
//
// Ports:
//   i_clk, i_reset        clock (posedge) and asynchronous active-high reset
//   i_start               one-cycle pulse, honoured only in IDLE or DONE
//   o_busy, o_done        sequence in progress / sequence complete
//   o_rf_*                register-file write broadcast (wen, 5b addr, 32b data)
//   o_dmem_*              data-memory write broadcast (wen, 4b addr, 32b data)
//   o_core_reset          reset to model and core, low only while streaming
//   o_prog_addr           program ROM address (ROM read is combinational)
//   i_prog_data           ROM word at o_prog_addr
//   o_instr               registered instruction to model and core
//   o_cycle_cnt           number of streaming cycles elapsed
//
// Optional macro INIT_RANDOM_EN: register init values come from a 32-bit
// Galois LFSR instead of the register index.

module verif_init_seq #(
  parameter int          NUM_REGS   = 32,
  parameter int          DMEM_WORDS = 16,
  parameter int          PROG_DEPTH = 16,
  parameter int          RESET_HOLD = 2,
  parameter int          RUN_CYCLES = 100,
  parameter logic [31:0] LFSR_SEED  = 32'h1,
  parameter logic [31:0] NOP_INSTR  = 32'h00000013,
  localparam int         PROG_AW    = $clog2(PROG_DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_rf_wen,
  output logic [4:0]         o_rf_waddr,
  output logic [31:0]        o_rf_wdata,
  output logic               o_dmem_wen,
  output logic [3:0]         o_dmem_waddr,
  output logic [31:0]        o_dmem_wdata,
  output logic               o_core_reset,
  output logic [PROG_AW-1:0] o_prog_addr,
  input  logic [31:0]        i_prog_data,
  output logic [31:0]        o_instr,
  output logic [31:0]        o_cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT_RF, S_INIT_DMEM, S_HOLD, S_RUN, S_DONE
  } state_t;

  localparam logic [4:0]  RF_LAST   = 5'(NUM_REGS - 1);
  localparam logic [4:0]  DM_LAST   = 5'(DMEM_WORDS - 1);
  localparam logic [4:0]  HOLD_LAST = 5'(RESET_HOLD - 1);
  localparam logic [31:0] RUN_LAST  = 32'(RUN_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [4:0]  r_idx, w_idx_nxt;     // shared step index for RF, DMEM and HOLD
  logic [31:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [31:0] w_rf_val;

`ifdef INIT_RANDOM_EN
  // Seed 0 would lock the LFSR at zero, so it is promoted to 1.
  localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [31:0] LFSR_MASK = 32'h80200003;

  logic [31:0] r_lfsr, w_lfsr_step;

  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ LFSR_MASK) : (r_lfsr >> 1);

  // Not reseeded on start: successive runs see a continuing sequence.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                 r_lfsr <= SEED_EFF;
    else if (r_state == S_INIT_RF) r_lfsr <= w_lfsr_step;
  end

  assign w_rf_val = r_lfsr;
`else
  logic w_unused_seed;
  assign w_unused_seed = ^LFSR_SEED;
  assign w_rf_val      = {27'b0, r_idx};
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx   <= '0;
      r_cnt   <= '0;
      r_instr <= NOP_INSTR;
    end else begin
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_instr <= w_instr_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cnt_nxt    = r_cnt;
    w_instr_nxt  = NOP_INSTR;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    o_rf_wen     = 1'b0;
    o_rf_waddr   = '0;
    o_rf_wdata   = '0;
    o_dmem_wen   = 1'b0;
    o_dmem_waddr = '0;
    o_dmem_wdata = '0;
    o_core_reset = 1'b1;
    case (r_state)
      S_IDLE, S_DONE: begin
        o_done = (r_state == S_DONE);
        if (i_start) begin
          w_state_nxt = S_INIT_RF;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      end
      S_INIT_RF: begin
        o_busy     = 1'b1;
        o_rf_wen   = 1'b1;
        o_rf_waddr = r_idx;
        o_rf_wdata = w_rf_val;
        if (r_idx == RF_LAST) begin
          w_state_nxt = S_INIT_DMEM;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 5'd1;
        end
      end
      S_INIT_DMEM: begin
        o_busy       = 1'b1;
        o_dmem_wen   = 1'b1;
        o_dmem_waddr = r_idx[3:0];
        o_dmem_wdata = {8{r_idx[3:0]}};
        if (r_idx == DM_LAST) begin
          w_state_nxt = S_HOLD;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 5'd1;
        end
      end
      S_HOLD: begin
        o_busy = 1'b1;
        if (r_idx == HOLD_LAST) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 5'd1;
        end
      end
      S_RUN: begin
        o_busy       = 1'b1;
        o_core_reset = 1'b0;
        // The final RUN edge loads NOP and freezes the count at RUN_CYCLES-1.
        if (r_cnt == RUN_LAST) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt   = r_cnt + 32'd1;
          w_instr_nxt = i_prog_data;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Power-of-two depth: the low count bits give the wrapping ROM address.
  assign o_prog_addr = r_cnt[PROG_AW-1:0];
  assign o_instr     = r_instr;
  assign o_cycle_cnt = r_cnt;

endmodule

// File: tb/tb_verif_init_seq.sv
module tb_verif_init_seq;
  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] SEED = 32'h1;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, rf_wen, dmem_wen, core_reset;
  logic [4:0]  rf_waddr;
  logic [3:0]  dmem_waddr, prog_addr;
  logic [31:0] rf_wdata, dmem_wdata, prog_data, instr, cycle_cnt;
  logic [31:0] rom [16];

  verif_init_seq dut (
    .i_clk(clk), .i_reset(rst), .i_start(start),
    .o_busy(busy), .o_done(done),
    .o_rf_wen(rf_wen), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_dmem_wen(dmem_wen), .o_dmem_waddr(dmem_waddr), .o_dmem_wdata(dmem_wdata),
    .o_core_reset(core_reset), .o_prog_addr(prog_addr), .i_prog_data(prog_data),
    .o_instr(instr), .o_cycle_cnt(cycle_cnt)
  );

  assign prog_data = rom[prog_addr];
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int start_cyc = 0;
  int last_dmem_cyc = 0;
  logic prev_cr = 1'b1;
  logic [31:0] m_lfsr;

  logic [36:0] rf_q   [$];   // {addr, data}
  logic [35:0] dmem_q [$];   // {addr, data}
  logic [63:0] run_q  [$];   // {instr, cycle_cnt} per streaming cycle

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] galois(input logic [31:0] v);
    logic [31:0] s;
    s = v >> 1;
    if (v % 2 == 1) s = s ^ 32'h80200003;
    return s;
  endfunction

  task automatic chk_reset_vals();
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_rf_wen", {31'b0, rf_wen}, 0);
    chk("rst_dmem_wen", {31'b0, dmem_wen}, 0);
    chk("rst_rf_waddr", {27'b0, rf_waddr}, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_dmem_waddr", {28'b0, dmem_waddr}, 0);
    chk("rst_dmem_wdata", dmem_wdata, 0);
    chk("rst_core_reset", {31'b0, core_reset}, 1);
    chk("rst_prog_addr", {28'b0, prog_addr}, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_cycle_cnt", cycle_cnt, 0);
  endtask

  // Reference model: full expected transaction list for one accepted start.
  task automatic push_expect();
    logic [31:0] d;
    for (int i = 0; i < 32; i++) begin
`ifdef INIT_RANDOM_EN
      d = m_lfsr;
      m_lfsr = galois(m_lfsr);
`else
      d = 32'(i);
`endif
      rf_q.push_back({5'(i), d});
    end
    for (int i = 0; i < 16; i++)
      dmem_q.push_back({4'(i), 32'(i) * 32'h11111111});
    for (int k = 0; k < 100; k++)
      run_q.push_back({(k == 0) ? NOP : rom[(k - 1) % 16], 32'(k)});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  always @(negedge clk) begin
    logic [36:0] er;
    logic [35:0] ed;
    logic [63:0] ei;
    if (rst) begin
      prev_cr = 1'b1;
    end else begin
      if (rf_wen) begin
        chk("wen_exclusive", {31'b0, dmem_wen}, 0);
        chk("rf_pending", {31'b0, rf_q.size() != 0}, 1);
        if (rf_q.size() != 0) begin
          er = rf_q.pop_front();
          chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, er[36:32]});
          chk("rf_wdata", rf_wdata, er[31:0]);
        end
      end
      if (dmem_wen) begin
        last_dmem_cyc = cyc;
        chk("dmem_pending", {31'b0, dmem_q.size() != 0}, 1);
        if (dmem_q.size() != 0) begin
          ed = dmem_q.pop_front();
          chk("dmem_waddr", {28'b0, dmem_waddr}, {28'b0, ed[35:32]});
          chk("dmem_wdata", dmem_wdata, ed[31:0]);
        end
      end
      if (!core_reset) begin
        if (prev_cr) begin
          chk("hold_gap", 32'(cyc - last_dmem_cyc), 3);
          chk("start_latency", 32'(cyc - start_cyc), 51);
        end
        chk("run_pending", {31'b0, run_q.size() != 0}, 1);
        if (run_q.size() != 0) begin
          ei = run_q.pop_front();
          chk("instr", instr, ei[63:32]);
          chk("cycle_cnt", cycle_cnt, ei[31:0]);
        end
      end
      prev_cr = core_reset;
    end
  end

  // One start; optional ignored pulses (INIT_RF, RUN, and the DONE-entry
  // edge) and optional abort by async reset at a given offset.
  task automatic run_seq(input bit pulses, input int abort_at);
    int p1, p2;
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    p1 = $urandom_range(2, 30);
    p2 = $urandom_range(55, 145);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    push_expect();
    for (int off = 1; off <= 156; off++) begin
      @(negedge clk);
      chk("busy", {31'b0, busy}, {31'b0, off <= 150});
      chk("done", {31'b0, done}, {31'b0, off >= 151});
      chk("core_reset", {31'b0, core_reset}, {31'b0, !(off >= 51 && off <= 150)});
      if (off == abort_at) begin
        chk("abort_word", {28'b0, dmem_waddr}, 7);
        #2 rst = 1'b1;
        #1 chk_reset_vals();
        rf_q.delete();
        dmem_q.delete();
        run_q.delete();
        m_lfsr = (SEED == 32'h0) ? 32'h1 : SEED;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      start = pulses && (off == p1 || off == p2 || off == 150);
    end
    chk("done_instr", instr, NOP);
    chk("done_cycle_cnt", cycle_cnt, 99);
    chk("rf_leftover", rf_q.size(), 0);
    chk("dmem_leftover", dmem_q.size(), 0);
    chk("run_leftover", run_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    m_lfsr = (SEED == 32'h0) ? 32'h1 : SEED;
    for (int i = 0; i < 16; i++) rom[i] = $urandom;
    #3 chk_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_seq(1'b0, 0);
    run_seq(1'b0, 0);
    run_seq(1'b1, 0);
    run_seq(1'b0, 40);
    run_seq(1'b1, 0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
